me_sad_search: RTL and testbench

- Parametrised full-search block-matching motion estimator for the video-coding datapath.
- Consumes one row of target and candidate reference pixels per accepted beat.
- Accumulates an exact SAD per candidate over the (2*RANGE+1)^2 search window.
- Reports the best motion vector and its cost with a one-cycle valid pulse.
- Successor to the fixed 8x8, ±4, truncated-average estimator: adds exact SAD, configurable geometry, stall-tolerant input, abort/restart, a busy flag and a cost output.

---
 rtl/me_sad_search.sv | 198 +++++++++++++++++++
 tb/tb_me_sad_search.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_sad_search.sv
`timescale 1ns/1ps
// Full-search block-matching motion estimator: exact SAD over a
// (2*RANGE+1)^2 window, one block row per beat, best MV + cost out.
// Ports: clk, rst_n (async low), start_i, in_valid_i, target_i, ref_i,
//        busy_o, valid_o, mv_row_o, mv_col_o, best_sad_o.
module me_sad_search #(
   parameter int PIX_W = 8,
   parameter int LANES = 8,
   parameter int ROWS  = 8,
   parameter int RANGE = 4,
   localparam int MV_W  = $clog2(RANGE+1)+1,
   localparam int SAD_W = PIX_W + $clog2(LANES*ROWS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_i,
   input  logic                   in_valid_i,
   input  logic [LANES*PIX_W-1:0] target_i,
   input  logic [LANES*PIX_W-1:0] ref_i,
   output logic                   busy_o,
   output logic                   valid_o,
   output logic [MV_W-1:0]        mv_row_o,
   output logic [MV_W-1:0]        mv_col_o,
   output logic [SAD_W-1:0]       best_sad_o
);

   localparam int NSIDE = 2*RANGE+1;
   localparam int IDX_W = (NSIDE > 1) ? $clog2(NSIDE) : 1;
   localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int S2_W  = PIX_W + $clog2(LANES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSIDE-1);
   localparam logic [RW-1:0]    ROW_LAST = RW'(ROWS-1);

   logic [RW-1:0]    row_cnt;
   logic [IDX_W-1:0] cr, cc;
   logic             accept, abort;
   logic             last_row, last_cand, first_cand;

   assign accept     = busy_o && in_valid_i && !start_i;
   assign abort      = start_i && busy_o;
   assign last_row   = (row_cnt == ROW_LAST);
   assign last_cand  = (cr == IDX_LAST) && (cc == IDX_LAST);
   assign first_cand = (cr == '0) && (cc == '0);

   // S1 .. S3 registers and their tags
   logic             v1, f1, l1, lc1, fc1;
   logic [IDX_W-1:0] cr1, cc1;
   logic [PIX_W-1:0] d1 [LANES];
   logic             v2, f2, l2, lc2, fc2;
   logic [IDX_W-1:0] cr2, cc2;
   logic [S2_W-1:0]  sum2;
   logic             v3, l3, lc3, fc3;
   logic [IDX_W-1:0] cr3, cc3;
   logic [SAD_W-1:0] acc3;

   logic [SAD_W-1:0] best;
   logic [IDX_W-1:0] best_r, best_c;

   logic [PIX_W-1:0] ad [LANES];
   logic [S2_W-1:0]  lsum;

   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         ad[k] = (target_i[k*PIX_W +: PIX_W] > ref_i[k*PIX_W +: PIX_W])
               ? target_i[k*PIX_W +: PIX_W] - ref_i[k*PIX_W +: PIX_W]
               : ref_i[k*PIX_W +: PIX_W] - target_i[k*PIX_W +: PIX_W];
      end
   end

   always_comb begin
      lsum = '0;
      for (int k = 0; k < LANES; k++) begin
         lsum = lsum + S2_W'(d1[k]);
      end
   end

   // Compare against all-ones on the first candidate of a search so a
   // back-to-back search never disturbs the one still draining ahead.
   logic [SAD_W-1:0] base, nbest;
   logic [IDX_W-1:0] nbr, nbc;
   logic             better;

   always_comb begin
      base   = fc3 ? '1 : best;
      better = (acc3 < base);
      nbest  = better ? acc3 : base;
      nbr    = better ? cr3 : best_r;
      nbc    = better ? cc3 : best_c;
   end

   function automatic logic [MV_W-1:0] to_mv(input logic [IDX_W-1:0] i);
      return MV_W'(i) - MV_W'(RANGE);
   endfunction

   // Beat sequencing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_o  <= 1'b0;
         row_cnt <= '0;
         cr      <= '0;
         cc      <= '0;
      end else if (start_i) begin
         busy_o  <= 1'b1;
         row_cnt <= '0;
         cr      <= '0;
         cc      <= '0;
      end else if (accept) begin
         if (last_row) begin
            row_cnt <= '0;
            if (cc == IDX_LAST) begin
               cc <= '0;
               if (cr == IDX_LAST) begin
                  cr     <= '0;
                  busy_o <= 1'b0;
               end else begin
                  cr <= cr + IDX_W'(1);
               end
            end else begin
               cc <= cc + IDX_W'(1);
            end
         end else begin
            row_cnt <= row_cnt + RW'(1);
         end
      end
   end

   // Datapath pipeline
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0; f1 <= 1'b0; l1 <= 1'b0; lc1 <= 1'b0; fc1 <= 1'b0;
         cr1 <= '0; cc1 <= '0;
         for (int k = 0; k < LANES; k++) d1[k] <= '0;
         v2 <= 1'b0; f2 <= 1'b0; l2 <= 1'b0; lc2 <= 1'b0; fc2 <= 1'b0;
         cr2 <= '0; cc2 <= '0; sum2 <= '0;
         v3 <= 1'b0; l3 <= 1'b0; lc3 <= 1'b0; fc3 <= 1'b0;
         cr3 <= '0; cc3 <= '0; acc3 <= '0;
      end else begin
         v1 <= accept;
         v2 <= abort ? 1'b0 : v1;
         v3 <= abort ? 1'b0 : v2;
         if (accept) begin
            f1  <= (row_cnt == '0);
            l1  <= last_row;
            lc1 <= last_cand;
            fc1 <= first_cand;
            cr1 <= cr;
            cc1 <= cc;
            for (int k = 0; k < LANES; k++) d1[k] <= ad[k];
         end
         if (v1) begin
            f2   <= f1;
            l2   <= l1;
            lc2  <= lc1;
            fc2  <= fc1;
            cr2  <= cr1;
            cc2  <= cc1;
            sum2 <= lsum;
         end
         if (v2) begin
            l3   <= l2;
            lc3  <= lc2;
            fc3  <= fc2;
            cr3  <= cr2;
            cc3  <= cc2;
            acc3 <= f2 ? SAD_W'(sum2) : acc3 + SAD_W'(sum2);
         end
      end
   end

   // Best tracking and result strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         best       <= '1;
         best_r     <= '0;
         best_c     <= '0;
         valid_o    <= 1'b0;
         mv_row_o   <= '0;
         mv_col_o   <= '0;
         best_sad_o <= '0;
      end else begin
         valid_o <= v3 && l3 && lc3;
         if (v3 && l3) begin
            best   <= nbest;
            best_r <= nbr;
            best_c <= nbc;
            if (lc3) begin
               mv_row_o   <= to_mv(nbr);
               mv_col_o   <= to_mv(nbc);
               best_sad_o <= nbest;
            end
         end
         if (start_i && (busy_o || !(v1 || v2 || v3))) begin
            best <= '1;
         end
      end
   end

endmodule

// File: tb/tb_me_sad_search.sv
`timescale 1ns/1ps
// Bench for me_sad_search: random pixel streams, SAD reference model,
// stalls, abort, back-to-back and mid-search reset.
module tb_me_sad_search;

   localparam int PIX_W = 8;
   localparam int LANES = 8;
   localparam int ROWS  = 8;
   localparam int RANGE = 4;
   localparam int NSIDE = 2*RANGE+1;
   localparam int NCAND = NSIDE*NSIDE;
   localparam int NBEAT = NCAND*ROWS;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   start_i = 1'b0;
   logic                   in_valid_i = 1'b0;
   logic [LANES*PIX_W-1:0] target_i = '0;
   logic [LANES*PIX_W-1:0] ref_i = '0;
   logic                   busy_o;
   logic                   valid_o;
   logic [3:0]             mv_row_o;
   logic [3:0]             mv_col_o;
   logic [13:0]            best_sad_o;

   me_sad_search #(
      .PIX_W(PIX_W), .LANES(LANES), .ROWS(ROWS), .RANGE(RANGE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i),
      .in_valid_i(in_valid_i), .target_i(target_i), .ref_i(ref_i),
      .busy_o(busy_o), .valid_o(valid_o), .mv_row_o(mv_row_o),
      .mv_col_o(mv_col_o), .best_sad_o(best_sad_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [3:0]  r;
      logic [3:0]  c;
      logic [13:0] s;
   } pulse_t;
   pulse_t pq[$];

   always @(negedge clk) begin
      if (valid_o !== 1'b0) begin
         pulse_t p;
         p.cyc = cyc;
         p.r = mv_row_o;
         p.c = mv_col_o;
         p.s = best_sad_o;
         pq.push_back(p);
      end
   end

   int nassert = 0;
   int nfail = 0;

   logic [7:0] tgt [NBEAT][LANES];
   logic [7:0] rf  [NBEAT][LANES];
   int exp_r, exp_c, exp_s;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      nassert++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Build a stream and derive its best candidate by brute force.
   task automatic gen(input int mode);
      int sad [NCAND];
      int best, bi, c, d;
      logic [7:0] t;
      for (int b = 0; b < NBEAT; b++) begin
         c = b / ROWS;
         for (int k = 0; k < LANES; k++) begin
            t = 8'($urandom_range(0, 255));
            case (mode)
               0: begin
                  tgt[b][k] = t;
                  rf[b][k]  = (c == 33) ? t : ((t == 8'hFF) ? t - 8'd1 : t + 8'd1);
               end
               1: begin
                  tgt[b][k] = t;
                  rf[b][k]  = (t == 8'hFF) ? t - 8'd1 : t + 8'd1;
               end
               2: begin
                  tgt[b][k] = 8'hFF;
                  rf[b][k]  = (c == 80 && (b % ROWS) == 0 && k == 0) ? 8'd1 : 8'd0;
               end
               default: begin
                  tgt[b][k] = t;
                  rf[b][k]  = (c == 40) ? t : 8'($urandom_range(0, 255));
               end
            endcase
         end
      end
      for (int ci = 0; ci < NCAND; ci++) begin
         sad[ci] = 0;
         for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < LANES; k++) begin
               d = int'(tgt[ci*ROWS+r][k]) - int'(rf[ci*ROWS+r][k]);
               sad[ci] += (d < 0) ? -d : d;
            end
         end
      end
      best = sad[0];
      bi = 0;
      for (int ci = 1; ci < NCAND; ci++) begin
         if (sad[ci] < best) begin
            best = sad[ci];
            bi = ci;
         end
      end
      exp_r = bi / NSIDE - RANGE;
      exp_c = bi % NSIDE - RANGE;
      exp_s = best;
   endtask

   task automatic do_start();
      start_i = 1'b1;
      in_valid_i = 1'b1;
      target_i = {$urandom, $urandom};
      ref_i = {$urandom, $urandom};
      @(posedge clk); #1;
      start_i = 1'b0;
      in_valid_i = 1'b0;
      chk("busy_after_start", 32'(busy_o), 32'd1);
   endtask

   task automatic stream(input int nb, input int stall, output int e0);
      int b = 0;
      int guard = 0;
      while (b < nb && guard < 40000) begin
         in_valid_i = ($urandom_range(0, 99) >= stall);
         for (int k = 0; k < LANES; k++) begin
            target_i[k*PIX_W +: PIX_W] = tgt[b][k];
            ref_i[k*PIX_W +: PIX_W]    = rf[b][k];
         end
         @(posedge clk); #1;
         if (in_valid_i) b++;
         guard++;
      end
      in_valid_i = 1'b0;
      e0 = cyc;
      chk("stream_budget", 32'(b), 32'(nb));
      if (nb == NBEAT) chk("busy_fall", 32'(busy_o), 32'd0);
   endtask

   task automatic expect_result(input string tag, input int e0,
                                input int er, input int ec, input int es);
      int w = 0;
      pulse_t p;
      while (pq.size() == 0 && w < 12) begin
         @(posedge clk); #1;
         w++;
      end
      nassert++;
      assert (pq.size() > 0) else begin
         nfail++;
         $error("FAIL %s_timeout: observed no valid_o expected one pulse", tag);
      end
      if (pq.size() > 0) begin
         p = pq.pop_front();
         chk({tag, "_cyc"}, 32'(p.cyc), 32'(e0 + 3));
         chk({tag, "_mv_row"}, 32'(p.r), 32'(er) & 32'hF);
         chk({tag, "_mv_col"}, 32'(p.c), 32'(ec) & 32'hF);
         chk({tag, "_sad"}, 32'(p.s), 32'(es));
         chk({tag, "_pulse_len"},
             32'(pq.size() > 0 && pq[0].cyc == p.cyc + 1), 32'd0);
      end
   endtask

   initial begin
      int e0, e0a, ar, ac, as;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_mv_row", 32'(mv_row_o), 32'd0);
      chk("rst_mv_col", 32'(mv_col_o), 32'd0);
      chk("rst_sad", 32'(best_sad_o), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      gen(0);
      do_start();
      stream(NBEAT, 0, e0);
      expect_result("exact", e0, exp_r, exp_c, exp_s);
      repeat (5) @(posedge clk);
      #1;
      chk("hold_row", 32'(mv_row_o), 32'(exp_r) & 32'hF);
      chk("hold_sad", 32'(best_sad_o), 32'(exp_s));

      gen(1);
      do_start();
      stream(NBEAT, 0, e0);
      expect_result("tie", e0, exp_r, exp_c, exp_s);

      gen(2);
      do_start();
      stream(NBEAT, 0, e0);
      expect_result("maxdiff", e0, exp_r, exp_c, exp_s);

      do_start();
      stream(NBEAT, 50, e0);
      expect_result("stall", e0, exp_r, exp_c, exp_s);

      gen(0);
      do_start();
      stream(300, 30, e0);
      gen(3);
      do_start();
      stream(NBEAT, 20, e0);
      expect_result("abort", e0, exp_r, exp_c, exp_s);
      repeat (6) @(posedge clk);
      #1;
      chk("abort_pulses", 32'(pq.size()), 32'd0);

      gen(1);
      do_start();
      stream(NBEAT, 0, e0a);
      ar = exp_r;
      ac = exp_c;
      as = exp_s;
      gen(0);
      do_start();
      stream(NBEAT, 10, e0);
      expect_result("b2b_first", e0a, ar, ac, as);
      expect_result("b2b_second", e0, exp_r, exp_c, exp_s);

      gen(0);
      do_start();
      stream(100, 0, e0);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy_o), 32'd0);
      chk("midrst_mv_row", 32'(mv_row_o), 32'd0);
      chk("midrst_mv_col", 32'(mv_col_o), 32'd0);
      chk("midrst_sad", 32'(best_sad_o), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("midrst_no_valid", 32'(pq.size()), 32'd0);
      chk("midrst_busy_after", 32'(busy_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               nassert, nfail);
      $finish;
   end

endmodule
